// File: rtl/chu_video_pkg.sv
// Shared types and helpers for the pixel-stream blocks.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package chu_video_pkg;

  // Coordinate width driven to the daisy-chained video cores.
  localparam int COORD_W = 11;

  // Default colour depth and stream word layout: {rgb, sof}.
  localparam int CD_DEFAULT = 12;
  localparam int SOF_BIT    = 0;

  typedef logic [CD_DEFAULT:0] stream_word_t;

  // One stage of the issue-to-return delay line.
  typedef struct packed {
    logic vld;
    logic sof;
  } dly_stage_t;

  // Increment a coordinate, wrapping to zero after 'last'.
  function automatic logic [COORD_W-1:0] wrap_inc(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] last
  );
    return (v == last) ? '0 : v + COORD_W'(1);
  endfunction

endpackage

// File: rtl/chu_stream_fifo.sv
// Synchronous first-word-fall-through FIFO for stream words.
// Latency: a pushed word is visible at rd_data_o the cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored.
module chu_stream_fifo #(
  parameter int DEPTH = 4,
  parameter int DW    = 13
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          pop_i,
  output logic          empty_o,
  output logic          full_o,
  output logic [DW-1:0] rd_data_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push   = push_i && !full_o;
  assign do_pop    = pop_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance for the accepted push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage; cleared on reset so the head reads zero while empty.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
    end
  end

endmodule

// File: rtl/chu_vga_stream_src.sv
// Scans x/y into the video chain, re-aligns the returning RGB and streams {rgb, sof}.
// Latency: PIPE+1 cycles from issue of a coordinate to the pixel on so_data.
// Backpressure: credit counter stops issuing when DEPTH pixels are in flight or buffered.
module chu_vga_stream_src #(
  parameter int CD    = 12,
  parameter int HMAX  = 640,
  parameter int VMAX  = 480,
  parameter int PIPE  = 2,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          sync_clr,
  output logic [10:0]   x,
  output logic [10:0]   y,
  input  logic [CD-1:0] si_rgb,
  output logic [CD:0]   so_data,
  output logic          so_valid,
  input  logic          so_ready,
  output logic          frame_end
);

  import chu_video_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(HMAX - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(VMAX - 1);

  logic [COORD_W-1:0] x_q, x_d;
  logic [COORD_W-1:0] y_q, y_d;
  logic [CW-1:0]      credit_q, credit_d;
  dly_stage_t         dly_q [PIPE];
  logic               issue, sof_tag, pop, push;
  logic               fifo_empty, fifo_full;
  logic [CD:0]        push_dat;

  // The chain cannot stall, so a coordinate is only issued when a FIFO slot is reserved.
  assign issue     = en && (credit_q != '0);
  assign sof_tag   = (x_q == '0) && (y_q == '0);
  assign frame_end = issue && (x_q == X_LAST) && (y_q == Y_LAST);
  assign pop       = so_valid && so_ready;
  assign x         = x_q;
  assign y         = y_q;

  // Next scan position; sync_clr wins, the pixel issued alongside it keeps its old coordinates.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (sync_clr) begin
      x_d = '0;
      y_d = '0;
    end else if (issue) begin
      x_d = wrap_inc(x_q, X_LAST);
      if (x_q == X_LAST) y_d = wrap_inc(y_q, Y_LAST);
    end
  end

  // Scan position registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Delay line tracking which cycles carry a pixel back from the chain, and its sof tag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < PIPE; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= '{vld: issue, sof: sof_tag};
      for (int i = 1; i < PIPE; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  // Pair the returning colour with the tag that left alongside its coordinates.
  always_comb begin
    push_dat          = {si_rgb, 1'b0};
    push_dat[SOF_BIT] = dly_q[PIPE-1].sof;
  end
  assign push = dly_q[PIPE-1].vld;

  // Credits: one consumed per issue, one returned per pop; simultaneous events cancel.
  always_comb begin
    credit_d = credit_q;
    case ({issue, pop})
      2'b10:   credit_d = credit_q - CW'(1);
      2'b01:   credit_d = credit_q + CW'(1);
      default: credit_d = credit_q;
    endcase
  end

  // Credit register, full allowance after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) credit_q <= CW'(DEPTH);
    else        credit_q <= credit_d;
  end

  chu_stream_fifo #(
    .DEPTH (DEPTH),
    .DW    (CD + 1)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push_i    (push),
    .wr_data_i (push_dat),
    .pop_i     (pop),
    .empty_o   (fifo_empty),
    .full_o    (fifo_full),
    .rd_data_o (so_data)
  );

  assign so_valid = !fifo_empty;

  // Credits keep the FIFO from ever overflowing; full is only meaningful to other users.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule

// File: tb/tb_chu_vga_stream_src.sv
// Scoreboard bench: expected pixels queued in scan order, a monitor pops on each handshake.
module tb_chu_vga_stream_src;

  localparam int CD    = 12;
  localparam int HMAX  = 8;
  localparam int VMAX  = 4;
  localparam int PIPE  = 2;
  localparam int DEPTH = 4;
  localparam int NPIX  = HMAX * VMAX;

  logic          clk = 1'b0;
  logic          reset;
  logic          en;
  logic          sync_clr;
  logic [10:0]   x, y;
  logic [CD-1:0] si_rgb;
  logic [CD:0]   so_data;
  logic          so_valid;
  logic          so_ready;
  logic          frame_end;

  // Chain model: two register stages, colour = {x[5:0], y[5:0]}.
  logic [10:0] xd1 = '0, xd2 = '0, yd1 = '0, yd2 = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    xd1 <= x;
    xd2 <= xd1;
    yd1 <= y;
    yd2 <= yd1;
  end
  assign si_rgb = {xd2[5:0], yd2[5:0]};

  chu_vga_stream_src #(
    .CD(CD), .HMAX(HMAX), .VMAX(VMAX), .PIPE(PIPE), .DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .sync_clr  (sync_clr),
    .x         (x),
    .y         (y),
    .si_rgb    (si_rgb),
    .so_data   (so_data),
    .so_valid  (so_valid),
    .so_ready  (so_ready),
    .frame_end (frame_end)
  );

  int          n_tests    = 0;
  int          n_fail     = 0;
  int          pop_cnt    = 0;
  int          frame_pops = 0;
  int          fe_cnt     = 0;
  int          sb_pos     = 0;
  logic [CD:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected word for linear scan index idx (within a frame).
  function automatic logic [CD:0] pix_word(input int idx);
    int px, py;
    logic [10:0] bx, by;
    px = idx % HMAX;
    py = (idx / HMAX) % VMAX;
    bx = 11'(px);
    by = 11'(py);
    return {bx[5:0], by[5:0], (px == 0 && py == 0)};
  endfunction

  task automatic push_one();
    exp_q.push_back(pix_word(sb_pos % NPIX));
    sb_pos++;
  endtask

  // Monitor: compare each accepted word with the scoreboard head; check frame_end position.
  always @(negedge clk) begin
    if (reset && so_valid && so_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL pixel: got %0h, expected no word", so_data);
      end else begin
        chk("pixel", 32'(so_data), 32'(exp_q.pop_front()));
      end
      pop_cnt++;
      frame_pops = so_data[0] ? 1 : frame_pops + 1;
    end
    if (reset && frame_end) begin
      fe_cnt++;
      chk("frame_end_xy", 32'({y, x}), 32'({11'(VMAX - 1), 11'(HMAX - 1)}));
    end
  end

  // Stop issuing and let the delay line and FIFO empty out.
  task automatic drain();
    @(posedge clk); #1;
    en       = 1'b0;
    so_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("drained_valid", 32'(so_valid), 32'd0);
  endtask

  // Everything delivered so far must match the DUT scan position; rebase the scoreboard.
  task automatic resync();
    int p;
    p = frame_pops % NPIX;
    chk("scan_pos", 32'({y, x}), 32'({11'(p / HMAX), 11'(p % HMAX)}));
    exp_q.delete();
    sb_pos = p;
  endtask

  // Latency checks after a reset release made at the start of cycle 0.
  task automatic first_pixels(input string tag);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 2) chk({tag, "_quiet_c2"}, 32'(so_valid), 32'd0);
      if (c == 3) begin
        chk({tag, "_vld_c3"}, 32'(so_valid), 32'd1);
        chk({tag, "_dat_c3"}, 32'(so_data), 32'h0001);
      end
      if (c == 4) chk({tag, "_dat_c4"}, 32'(so_data), 32'({12'h040, 1'b0}));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, target, fe_base, idx, cyc;
    bit found;

    reset    = 1'b0;
    en       = 1'b0;
    sync_clr = 1'b0;
    so_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(so_valid), 32'd0);
    chk("rst_data",  32'(so_data),  32'd0);
    chk("rst_xy",    32'({y, x}),   32'd0);
    chk("rst_fe",    32'(frame_end), 32'd0);

    // Tests 1+2: first-pixel latency, then one full frame at full rate.
    sb_pos = 0;
    repeat (NPIX) push_one();
    en    = 1'b1;
    reset = 1'b1;
    first_pixels("t1");
    repeat (NPIX - 5) @(posedge clk);
    #1;
    en = 1'b0;
    chk("t2_xy_wrap", 32'({y, x}), 32'd0);
    chk("t2_fe_once", 32'(fe_cnt), 32'd1);
    drain();
    chk("t2_pop_cnt", 32'(pop_cnt), 32'(NPIX));
    resync();

    // Test 3: consumer stalled; issue stops at DEPTH, then burst out at 1/clk.
    repeat (DEPTH) push_one();
    so_ready = 1'b0;
    en       = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t3_xy_stop",  32'({y, x}),  32'({11'd0, 11'(DEPTH)}));
    chk("t3_hold_vld", 32'(so_valid), 32'd1);
    chk("t3_hold_dat", 32'(so_data),  32'h0001);
    en       = 1'b0;
    so_ready = 1'b1;
    base     = pop_cnt;
    repeat (DEPTH) begin
      @(negedge clk);
      chk("t3_burst_vld", 32'(so_valid), 32'd1);
    end
    @(posedge clk); #1;
    chk("t3_burst_cnt", 32'(pop_cnt - base), 32'(DEPTH));
    chk("t3_empty",     32'(so_valid), 32'd0);
    resync();

    // Test 4: random backpressure over three frames.
    target  = pop_cnt + 3 * NPIX;
    fe_base = fe_cnt;
    repeat (3 * NPIX + 16) push_one();
    en  = 1'b1;
    cyc = 0;
    while (pop_cnt < target && cyc < 3000) begin
      so_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
    end
    chk("t4_reached", 32'(pop_cnt >= target), 32'd1);
    drain();
    chk("t4_fe_cnt", 32'(fe_cnt - fe_base), 32'd3);
    resync();

    // Test 5: sync_clr while (5,2) is issued; in-flight pixels still delivered.
    do begin
      idx = sb_pos % NPIX;
      push_one();
    end while (idx != 2 * HMAX + 5);
    sb_pos = 0;
    repeat (40) push_one();
    en       = 1'b1;
    so_ready = 1'b1;
    found    = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (x == 11'd5 && y == 11'd2) begin
        sync_clr = 1'b1;
        found    = 1'b1;
        @(posedge clk); #1;
        sync_clr = 1'b0;
        chk("t5_xy_clr", 32'({y, x}), 32'd0);
        break;
      end
      @(posedge clk); #1;
    end
    chk("t5_found", 32'(found), 32'd1);
    repeat (8) @(posedge clk);
    #1;
    drain();
    resync();

    // Test 6: reset with three words buffered, then restart.
    so_ready = 1'b0;
    en       = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_pre_vld", 32'(so_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("t6_rst_vld", 32'(so_valid), 32'd0);
    chk("t6_rst_xy",  32'({y, x}),   32'd0);
    chk("t6_rst_dat", 32'(so_data),  32'd0);
    exp_q.delete();
    frame_pops = 0;
    sb_pos     = 0;
    en         = 1'b0;
    so_ready   = 1'b1;
    repeat (8) push_one();
    repeat (2) @(posedge clk);
    #1;
    en    = 1'b1;
    reset = 1'b1;
    first_pixels("t6");
    drain();
    resync();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
